// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline flush/redirect controller.
// Contents: FSM state enum, event codes, default stage count and PC width.
// No logic; imported by pipeline_flush_ctrl and its testbench.
package pipeline_pkg;

  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_PC_WIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  // Event accepted this cycle, after priority and busy filtering.
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_BRANCH = 2'd1,
    EV_EXC    = 2'd2
  } event_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per enabled cycle, sticks at all-ones.
// Ports: clk, rst (async active-high), i_inc enable, o_count value.
// Latency: count visible the cycle after i_inc.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Flush/redirect controller: turns branch-taken and exception events into a
// per-stage flush vector (held >= FLUSH_CYCLES, stretched by stall_i), a
// valid/ready fetch redirect, a busy flag and a saturating event counter.
// Ports: events in (branch_taken_i/target, exc_req_i/vector), stall_i,
// redirect_ready_i; outputs flush_o, redirect_valid_o/pc_o, busy_o, flush_count_o.
// All outputs registered; event at cycle N is visible at N+1.
module pipeline_flush_ctrl
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int BR_STAGE     = 2,
  parameter int EXC_STAGE    = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_taken_i,
  input  logic [PC_WIDTH-1:0]   branch_target_i,
  input  logic                  exc_req_i,
  input  logic [PC_WIDTH-1:0]   exc_vector_i,
  input  logic                  stall_i,
  input  logic                  redirect_ready_i,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_valid_o,
  output logic [PC_WIDTH-1:0]   redirect_pc_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  flush_count_o
);

  localparam int HOLD_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  // Branch flushes the stages younger than the resolving stage; an exception
  // also kills the excepting stage itself.
  localparam logic [NUM_STAGES-1:0] BR_MASK  =
    NUM_STAGES'((64'd1 << BR_STAGE) - 64'd1);
  localparam logic [NUM_STAGES-1:0] EXC_MASK =
    NUM_STAGES'((64'd1 << (EXC_STAGE + 1)) - 64'd1);

  state_t                r_state;
  logic [HOLD_W-1:0]     r_hold;
  logic [NUM_STAGES-1:0] r_mask;
  logic [NUM_STAGES-1:0] r_flush;
  logic [PC_WIDTH-1:0]   r_pc;
  logic                  r_vld;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  logic [NUM_STAGES-1:0] w_mask_nxt;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic                  w_vld_nxt;
  logic                  w_inc;
  event_t                w_ev;

  // Exceptions are always taken; a branch only counts when idle, since
  // while busy it sits on a path that is already being flushed.
  always_comb begin
    w_ev = EV_NONE;
    if (exc_req_i) begin
      w_ev = EV_EXC;
    end else if (branch_taken_i && (r_state == ST_IDLE)) begin
      w_ev = EV_BRANCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_mask  <= '0;
      r_flush <= '0;
      r_pc    <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_mask  <= w_mask_nxt;
      r_flush <= (w_state_nxt == ST_FLUSH) ? w_mask_nxt : '0;
      r_pc    <= w_pc_nxt;
      r_vld   <= w_vld_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_mask_nxt  = r_mask;
    w_pc_nxt    = r_pc;
    // A completed handshake drops valid; a new event re-arms it below.
    w_vld_nxt   = r_vld && !redirect_ready_i;
    w_inc       = 1'b0;

    if (w_ev != EV_NONE) begin
      w_state_nxt = ST_FLUSH;
      w_hold_nxt  = HOLD_W'(FLUSH_CYCLES);
      w_vld_nxt   = 1'b1;
      w_inc       = 1'b1;
      if (w_ev == EV_EXC) begin
        w_pc_nxt   = exc_vector_i;
        w_mask_nxt = ((r_state == ST_IDLE) ? '0 : r_mask) | EXC_MASK;
      end else begin
        w_pc_nxt   = branch_target_i;
        w_mask_nxt = BR_MASK;
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          if (!stall_i) begin
            w_hold_nxt = r_hold - HOLD_W'(1);
            if (r_hold == HOLD_W'(1)) begin
              w_state_nxt = w_vld_nxt ? ST_WAIT_RDY : ST_IDLE;
            end
          end
        end
        ST_WAIT_RDY: begin
          if (redirect_ready_i) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .o_count (flush_count_o)
  );

  assign flush_o          = r_flush;
  assign redirect_valid_o = r_vld;
  assign redirect_pc_o    = r_pc;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Testbench for pipeline_flush_ctrl: directed scenarios plus randomized run
// against a behavioural model (remaining flush cycles, pending redirect flag).
// Second instance with a 2-bit counter exercises saturation.
module tb_pipeline_flush_ctrl;
  import pipeline_pkg::*;

  localparam int NS = 5;
  localparam int PW = 32;
  localparam int FC = 1;
  localparam logic [NS-1:0] M_BR  = 5'b00011;
  localparam logic [NS-1:0] M_EXC = 5'b01111;

  logic          clk = 1'b0;
  logic          rst;
  logic          branch_taken_i;
  logic [PW-1:0] branch_target_i;
  logic          exc_req_i;
  logic [PW-1:0] exc_vector_i;
  logic          stall_i;
  logic          redirect_ready_i;

  logic [NS-1:0] flush_o,  flush2;
  logic          vld_o,    vld2;
  logic [PW-1:0] pc_o,     pc2;
  logic          busy_o,   busy2;
  logic [15:0]   cnt_o;
  logic [1:0]    cnt2;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            m_left;
  bit            m_pend;
  logic [PW-1:0] m_pc;
  logic [NS-1:0] m_mask;
  int            m_cnt;
  int            m_cnt2;

  always #5 clk = ~clk;

  pipeline_flush_ctrl #(
    .NUM_STAGES(NS), .BR_STAGE(2), .EXC_STAGE(3), .FLUSH_CYCLES(FC),
    .PC_WIDTH(PW), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .exc_req_i(exc_req_i), .exc_vector_i(exc_vector_i),
    .stall_i(stall_i), .redirect_ready_i(redirect_ready_i),
    .flush_o(flush_o), .redirect_valid_o(vld_o), .redirect_pc_o(pc_o),
    .busy_o(busy_o), .flush_count_o(cnt_o)
  );

  pipeline_flush_ctrl #(
    .NUM_STAGES(NS), .BR_STAGE(2), .EXC_STAGE(3), .FLUSH_CYCLES(FC),
    .PC_WIDTH(PW), .CNT_WIDTH(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .exc_req_i(exc_req_i), .exc_vector_i(exc_vector_i),
    .stall_i(stall_i), .redirect_ready_i(redirect_ready_i),
    .flush_o(flush2), .redirect_valid_o(vld2), .redirect_pc_o(pc2),
    .busy_o(busy2), .flush_count_o(cnt2)
  );

  task automatic model_reset();
    m_left = 0; m_pend = 0; m_pc = '0; m_mask = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock of the controller's rules, using the inputs present at the edge.
  task automatic model_step();
    bit busy;
    busy = (m_left > 0) || m_pend;
    if (exc_req_i || (branch_taken_i && !busy)) begin
      if (exc_req_i) begin
        m_mask = (busy ? m_mask : 5'd0) | M_EXC;
        m_pc   = exc_vector_i;
      end else begin
        m_mask = M_BR;
        m_pc   = branch_target_i;
      end
      m_left = FC;
      m_pend = 1;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      if (m_pend && redirect_ready_i) m_pend = 0;
      if (m_left > 0 && !stall_i) m_left--;
    end
  endtask

  function automatic logic [95:0] exp_vec();
    logic [NS-1:0] f;
    logic          b;
    logic [15:0]   c;
    logic [1:0]    c2;
    f  = (m_left > 0) ? m_mask : 5'd0;
    b  = (m_left > 0) || m_pend;
    c  = m_cnt[15:0];
    c2 = m_cnt2[1:0];
    return {f, m_pend, m_pc, b, c, f, m_pend, m_pc, b, c2};
  endfunction

  wire [95:0] act_vec = {flush_o, vld_o, pc_o, busy_o, cnt_o,
                         flush2, vld2, pc2, busy2, cnt2};

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    branch_taken_i = 0; branch_target_i = '0; exc_req_i = 0;
    exc_vector_i = '0; stall_i = 0; redirect_ready_i = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (act_vec !== 96'd0) begin
      fails++; $display("FAIL reset_outputs got=%h want=0", act_vec);
    end
    tick();
    tests++;
    if (busy_o !== 1'b0 || flush_o !== 5'd0) begin
      fails++; $display("FAIL reset_idle busy=%b flush=%b want 0/00000", busy_o, flush_o);
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    branch_taken_i = 1; branch_target_i = 32'h40;
    tick();
    branch_taken_i = 0;
    tests++;
    if (flush_o !== 5'b00011 || vld_o !== 1'b1 || pc_o !== 32'h40 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL branch_n1 flush=%b vld=%b pc=%h busy=%b want 00011/1/40/1",
               flush_o, vld_o, pc_o, busy_o);
    end
    tick();
    tests++;
    if (busy_o !== 1'b0 || vld_o !== 1'b0 || flush_o !== 5'd0 || cnt_o !== 16'd1) begin
      fails++;
      $display("FAIL branch_n2 busy=%b vld=%b flush=%b cnt=%0d want 0/0/00000/1",
               busy_o, vld_o, flush_o, cnt_o);
    end
  endtask

  task automatic test_stall();
    int n;
    logic [NS-1:0] fl [6];
    do_reset();
    branch_taken_i = 1; branch_target_i = 32'h44;
    tick();
    branch_taken_i = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      stall_i = (i < 3);
      fl[i] = flush_o;
      if (flush_o === 5'b00011) n++;
      tick();
    end
    stall_i = 0;
    tests++;
    if (n != 4 || fl[3] !== 5'b00011 || fl[4] !== 5'd0) begin
      fail_stall: begin
        fails++;
        $display("FAIL stall_hold cycles=%0d fl3=%b fl4=%b want 4/00011/00000", n, fl[3], fl[4]);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    exc_req_i = 1; exc_vector_i = 32'h100;
    branch_taken_i = 1; branch_target_i = 32'h80;
    tick();
    exc_req_i = 0; branch_taken_i = 0;
    tests++;
    if (flush_o !== 5'b01111 || pc_o !== 32'h100 || cnt_o !== 16'd1) begin
      fails++;
      $display("FAIL simul flush=%b pc=%h cnt=%0d want 01111/100/1", flush_o, pc_o, cnt_o);
    end
  endtask

  task automatic test_override();
    do_reset();
    redirect_ready_i = 0;
    branch_taken_i = 1; branch_target_i = 32'h80;
    tick();
    branch_taken_i = 0;
    tick();
    tests++;
    if (flush_o !== 5'd0 || vld_o !== 1'b1 || pc_o !== 32'h80) begin
      fails++;
      $display("FAIL ovr_wait flush=%b vld=%b pc=%h want 00000/1/80", flush_o, vld_o, pc_o);
    end
    exc_req_i = 1; exc_vector_i = 32'h100;
    tick();
    exc_req_i = 0;
    tests++;
    if (pc_o !== 32'h100 || flush_o !== 5'b01111 || vld_o !== 1'b1 || cnt_o !== 16'd2) begin
      fails++;
      $display("FAIL ovr_exc pc=%h flush=%b vld=%b cnt=%0d want 100/01111/1/2",
               pc_o, flush_o, vld_o, cnt_o);
    end
    tick();
    branch_taken_i = 1; branch_target_i = 32'h200;
    tick();
    branch_taken_i = 0;
    tests++;
    if (cnt_o !== 16'd2 || pc_o !== 32'h100 || vld_o !== 1'b1 || flush_o !== 5'd0) begin
      fails++;
      $display("FAIL ovr_branch_ignored cnt=%0d pc=%h vld=%b flush=%b want 2/100/1/00000",
               cnt_o, pc_o, vld_o, flush_o);
    end
    redirect_ready_i = 1;
    tick();
    tests++;
    if (busy_o !== 1'b0 || vld_o !== 1'b0) begin
      fails++; $display("FAIL ovr_done busy=%b vld=%b want 0/0", busy_o, vld_o);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    redirect_ready_i = 0;
    branch_taken_i = 1; branch_target_i = 32'h1234;
    tick();
    branch_taken_i = 0;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (flush_o !== 5'd0 || vld_o !== 1'b1 || pc_o !== 32'h1234 || busy_o !== 1'b1) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_wait bad_cycles=%0d want 0", bad);
    end
    redirect_ready_i = 1;
    tick();
    tests++;
    if (busy_o !== 1'b0 || vld_o !== 1'b0) begin
      fails++; $display("FAIL bp_release busy=%b vld=%b want 0/0", busy_o, vld_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    redirect_ready_i = 0;
    branch_taken_i = 1; branch_target_i = 32'h40;
    tick();
    branch_taken_i = 0;
    #2;
    rst = 1;
    #1;
    tests++;
    if ({flush_o, vld_o, pc_o, busy_o, cnt_o} !== 55'd0) begin
      fails++;
      $display("FAIL async_reset flush=%b vld=%b pc=%h busy=%b cnt=%0d want all 0",
               flush_o, vld_o, pc_o, busy_o, cnt_o);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      branch_taken_i = 1; branch_target_i = 32'h10 * (i + 1);
      tick();
      branch_taken_i = 0;
      tick();
    end
    tests++;
    if (cnt2 !== 2'd3 || cnt_o !== 16'd5) begin
      fails++; $display("FAIL saturate cnt2=%0d cnt=%0d want 3/5", cnt2, cnt_o);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      branch_taken_i   = ($urandom_range(0, 99) < 30);
      branch_target_i  = $urandom;
      exc_req_i        = ($urandom_range(0, 99) < 8);
      exc_vector_i     = $urandom;
      stall_i          = ($urandom_range(0, 99) < 30);
      redirect_ready_i = ($urandom_range(0, 99) < 50);
      tick();
      tests++;
      if (act_vec !== exp_vec()) begin
        fails++;
        if (bad < 5)
          $display("FAIL random cyc=%0d got=%h want=%h", i, act_vec, exp_vec());
        bad++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_branch();
    test_stall();
    test_simultaneous();
    test_override();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_flush_ctrl.md
Name: pipeline_flush_ctrl

Overview:
Parametrised flush/redirect controller for an N-stage in-order pipeline. It accepts branch-taken and exception events and drives a per-stage flush vector whose mask depends on the event type. It holds flush for a configurable minimum time, extended while the pipeline is stalled. It issues a valid/ready PC redirect to the fetch unit and keeps a saturating flush-event counter. It sits between the EX/MEM resolution logic and the IF stage, replacing the single-wire branch-to-flush path.

Parameters:
NUM_STAGES, 5, number of pipeline stages; flush_o bit i maps to stage i (0 = IF).
BR_STAGE, 2, stage where branches resolve; a branch flushes stages 0..BR_STAGE-1.
EXC_STAGE, 3, stage where exceptions are taken; an exception flushes stages 0..EXC_STAGE inclusive.
FLUSH_CYCLES, 1, minimum cycles flush_o is held per event (>=1).
PC_WIDTH, 32, redirect address width.
CNT_WIDTH, 16, flush-event counter width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
branch_taken_i  in  1  branch resolved as taken this cycle
branch_target_i  in  PC_WIDTH  branch target, valid with branch_taken_i
exc_req_i  in  1  exception request this cycle
exc_vector_i  in  PC_WIDTH  handler address, valid with exc_req_i
stall_i  in  1  pipeline stalled; extends the flush hold
redirect_ready_i  in  1  fetch unit accepts the redirect
flush_o  out  NUM_STAGES  per-stage flush, registered
redirect_valid_o  out  1  redirect_pc_o valid
redirect_pc_o  out  PC_WIDTH  new fetch PC
busy_o  out  1  controller not IDLE
flush_count_o  out  CNT_WIDTH  accepted events, saturating

Behaviour:
- Reset (async, rst=1): state IDLE; flush_o=0, redirect_valid_o=0, redirect_pc_o=0, busy_o=0, flush_count_o=0, hold counter=0. Reset mid-flush aborts immediately; any pending redirect is dropped.
- Event priority: exc_req_i beats branch_taken_i in the same cycle. The branch is discarded; the exception mask and vector are used.
- Latency: event at cycle N gives flush_o, redirect_valid_o and busy_o asserted at N+1. All outputs are registered.
- Masks: BR_MASK has bits [BR_STAGE-1:0] set. EXC_MASK has bits [EXC_STAGE:0] set. Both are computed from parameters at elaboration.
- States:
  - IDLE: on an event, latch the target/vector into redirect_pc_o, load hold counter = FLUSH_CYCLES, load the mask, assert redirect_valid_o, count++, go to FLUSH.
  - FLUSH: flush_o = latched mask. Hold counter decrements only when stall_i=0. When the counter reaches 0: go to IDLE if the redirect has been accepted, else go to WAIT_RDY.
  - WAIT_RDY: flush_o=0, redirect_valid_o held. On redirect_ready_i, go to IDLE.
- Redirect handshake: transfer occurs on a cycle with redirect_valid_o && redirect_ready_i; redirect_valid_o deasserts the next cycle. While valid and not ready, redirect_pc_o is stable, except on exception override (below).
- Events while busy:
  - branch_taken_i is ignored; the branch is on the wrong path and is being flushed.
  - exc_req_i in FLUSH or WAIT_RDY is accepted: it overwrites redirect_pc_o, re-arms redirect_valid_o (even if already accepted), reloads the hold counter, ORs EXC_MASK into the mask, returns to FLUSH and increments the count.
  - Exception in the same cycle as the handshake completing: the exception wins; a new redirect is issued.
- Counter: increments by 1 per accepted event and saturates at all-ones; it never wraps.
- busy_o = (state != IDLE).

Decomposition:
- Shared package pipeline_pkg holds:
  - state enum localparams: ST_IDLE=2'd0, ST_FLUSH=2'd1, ST_WAIT_RDY=2'd2;
  - event-code constants EV_NONE, EV_BRANCH, EV_EXC;
  - default NUM_STAGES and PC_WIDTH.
- One natural sub-module: sat_counter (parametrised width, increment enable, saturating).
- The mask generation and FSM stay in the top module.

Test Plan:
- Branch, no stall: branch_taken_i=1, target=0x0000_0040 at cycle 10 -> cycle 11 flush_o=5'b00011, redirect_valid_o=1, pc=0x40; with ready=1, IDLE at cycle 12; count=1.
- Stall extension: branch, then stall_i=1 for 3 cycles, FLUSH_CYCLES=1 -> flush_o=5'b00011 held 4 cycles, drops the cycle after stall_i falls.
- Simultaneous events: exc_req_i=1 with vector 0x0000_0100 and branch_taken_i=1 with target 0x80 in the same cycle -> flush_o=5'b01111, redirect_pc_o=0x100, count=1.
- Exception override: branch to 0x80, ready held 0; exception 0x100 two cycles later -> redirect_pc_o switches to 0x100, flush mask 5'b01111, valid stays high until ready, count=2; a branch during WAIT_RDY leaves the count unchanged.
- Backpressure: redirect_ready_i=0 for 5 cycles after the flush ends -> WAIT_RDY, flush_o=0, valid=1, pc stable; ready=1 -> IDLE next cycle.
- Reset mid-op and saturation: assert rst during FLUSH -> all outputs 0 asynchronously. With CNT_WIDTH=2, 5 events -> flush_count_o=3.
